// File: rtl/audio_playback_ctrl_if.sv
// Bundle of the codec-side handshake, the transport commands and the sample-ROM
// bus seen by audio_playback_ctrl.
//   master : drives codec handshake, commands and ROM data (codec IF, control, ROM IP)
//   slave  : the sequencer; drives rom_addr, audio_output and the status pulses
interface audio_playback_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              sample_req;
  logic              sample_end;
  logic [15:0]       audio_input;
  logic [1:0]        mode;
  logic              cmd_play;
  logic              cmd_pause;
  logic              cmd_stop;
  logic              track_sel;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic [15:0]       audio_output;
  logic              playing;
  logic              track_done;
  logic              underrun;

  modport master (
    output sample_req, sample_end, audio_input, mode, cmd_play, cmd_pause, cmd_stop,
           track_sel, loop_en, rom_q,
    input  rom_addr, audio_output, playing, track_done, underrun
  );

  modport slave (
    input  sample_req, sample_end, audio_input, mode, cmd_play, cmd_pause, cmd_stop,
           track_sel, loop_en, rom_q,
    output rom_addr, audio_output, playing, track_done, underrun
  );
endinterface

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer between the codec sample handshake and a two-track sample ROM.
// Issues one ROM word per sample_req while playing, prefetches the next word, and
// implements play/pause/stop/loop. audio_output selects ROM data, the last ADC
// sample (feedback) or silence, and only changes on sample_req.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : audio_playback_ctrl_if.slave (codec handshake, commands, ROM bus, status)
module audio_playback_ctrl #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned TRACK0_START = 0,
  parameter int unsigned TRACK0_END   = 999999,
  parameter int unsigned TRACK1_START = 0,
  parameter int unsigned TRACK1_END   = 999999,
  parameter int unsigned ROM_LAT      = 2
) (
  input logic                   clk,
  input logic                   reset,
  audio_playback_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] T0_START = ADDR_W'(TRACK0_START);
  localparam logic [ADDR_W-1:0] T0_END   = ADDR_W'(TRACK0_END);
  localparam logic [ADDR_W-1:0] T1_START = ADDR_W'(TRACK1_START);
  localparam logic [ADDR_W-1:0] T1_END   = ADDR_W'(TRACK1_END);
  localparam logic [1:0]        LAT      = 2'(ROM_LAT);

  typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              trk_q, trk_d;
  logic [15:0]       out_q, out_d;
  logic [15:0]       last_q;
  logic [15:0]       fetched_q;
  logic              valid_q, pending_q;
  logic [1:0]        cnt_q;
  logic              done_q, done_d;
  logic              under_q, under_d;
  logic              load;
  logic              data_ok;
  logic [15:0]       data;
  logic [ADDR_W-1:0] trk_start, trk_end;

  // Once the latency counter has expired rom_q already holds the word, so it is
  // usable in that same cycle; this is what lets requests be ROM_LAT+1 apart.
  assign data_ok   = valid_q | (pending_q & (cnt_q == 2'd0));
  assign data      = valid_q ? fetched_q : bus.rom_q;
  assign trk_start = trk_q ? T1_START : T0_START;
  assign trk_end   = trk_q ? T1_END : T0_END;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: sample_req is handled against the current state first, then any
  // command is applied to the state that results from it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    trk_d   = trk_q;
    out_d   = out_q;
    done_d  = 1'b0;
    under_d = 1'b0;
    load    = 1'b0;

    if (bus.sample_req) begin
      case (bus.mode)
        2'b01: begin
          if (state_q == StPlay) begin
            if (data_ok) begin
              out_d = data;
              load  = 1'b1;
              if (addr_q == trk_end) begin
                done_d = 1'b1;
                if (bus.loop_en) begin
                  addr_d = trk_start;
                end else begin
                  state_d = StIdle;
                  addr_d  = T0_START;
                end
              end else begin
                addr_d = addr_q + ADDR_W'(1);
              end
            end else begin
              under_d = 1'b1;
            end
          end else begin
            out_d = 16'h0000;
          end
        end
        2'b10:   out_d = last_q;
        default: out_d = 16'h0000;
      endcase
    end

    if (bus.cmd_stop) begin
      if (state_d != StIdle) begin
        state_d = StIdle;
        addr_d  = T0_START;
        load    = 1'b1;
      end
    end else if (bus.cmd_play) begin
      if (state_d == StIdle) begin
        trk_d   = bus.track_sel;
        addr_d  = bus.track_sel ? T1_START : T0_START;
        load    = 1'b1;
        state_d = StPlay;
      end else if (state_d == StPause) begin
        // Resume reuses the word already fetched for the held address.
        state_d = StPlay;
      end
    end else if (bus.cmd_pause) begin
      if (state_d == StPlay) begin
        state_d = StPause;
      end
    end
  end

  // Datapath and prefetch
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= T0_START;
      trk_q     <= 1'b0;
      out_q     <= 16'h0000;
      last_q    <= 16'h0000;
      fetched_q <= 16'h0000;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= 2'd0;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      trk_q   <= trk_d;
      out_q   <= out_d;
      done_q  <= done_d;
      under_q <= under_d;
      if (bus.sample_end) begin
        last_q <= bus.audio_input;
      end
      if (load) begin
        cnt_q     <= LAT;
        pending_q <= 1'b1;
        valid_q   <= 1'b0;
      end else if (pending_q) begin
        if (cnt_q == 2'd0) begin
          fetched_q <= bus.rom_q;
          valid_q   <= 1'b1;
          pending_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    bus.rom_addr     = addr_q;
    bus.audio_output = out_q;
    bus.playing      = (state_q == StPlay);
    bus.track_done   = done_q;
    bus.underrun     = under_q;
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Self-checking bench for audio_playback_ctrl: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run, all cycles checked
// against a timestamp-based behavioural model with an emulated ROM.
module tb_audio_playback_ctrl;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned T0S = 0;
  localparam int unsigned T0E = 3;
  localparam int unsigned T1S = 16;
  localparam int unsigned T1E = 21;
  localparam int          LAT = 2;

  localparam logic [19:0] A0S = 20'(T0S);
  localparam logic [19:0] A0E = 20'(T0E);
  localparam logic [19:0] A1S = 20'(T1S);
  localparam logic [19:0] A1E = 20'(T1E);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_playback_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  audio_playback_ctrl #(
    .ADDR_W(ADDR_W), .TRACK0_START(T0S), .TRACK0_END(T0E),
    .TRACK1_START(T1S), .TRACK1_END(T1E), .ROM_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [15:0] rom_val(input logic [19:0] a);
    logic [15:0] t;
    t = a[15:0];
    return (t * 16'h0101) ^ 16'h5A3C;
  endfunction

  // ROM emulation: data appears LAT cycles after the address.
  logic [19:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.rom_q = rom_val(apipe[LAT-1]);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model; m_state 0=idle 1=play 2=pause. A word is usable once
  // LAT+1 edges have passed since its address was issued.
  int          m_state, m_le, n_edge;
  logic [19:0] m_addr;
  logic        m_trk, m_done, m_under, m_has;
  logic [15:0] m_out, m_last;

  task automatic model_step();
    int          st;
    logic [19:0] na, s, e;
    logic        ld;
    n_edge++;
    if (reset) begin
      m_state = 0; m_addr = A0S; m_trk = 1'b0; m_out = 16'h0; m_last = 16'h0;
      m_done = 1'b0; m_under = 1'b0; m_has = 1'b0;
    end else begin
      st = m_state; na = m_addr; ld = 1'b0; m_done = 1'b0; m_under = 1'b0;
      s = m_trk ? A1S : A0S;
      e = m_trk ? A1E : A0E;
      if (bus.sample_req) begin
        if (bus.mode == 2'b01) begin
          if (m_state == 1) begin
            if (m_has && n_edge >= m_le + LAT + 1) begin
              m_out = rom_val(m_addr);
              ld = 1'b1;
              if (m_addr == e) begin
                m_done = 1'b1;
                if (bus.loop_en) na = s;
                else begin st = 0; na = A0S; end
              end else na = m_addr + 20'd1;
            end else m_under = 1'b1;
          end else m_out = 16'h0;
        end else if (bus.mode == 2'b10) m_out = m_last;
        else m_out = 16'h0;
      end
      if (bus.sample_end) m_last = bus.audio_input;
      if (bus.cmd_stop) begin
        if (st != 0) begin st = 0; na = A0S; ld = 1'b1; end
      end else if (bus.cmd_play) begin
        if (st == 0) begin
          m_trk = bus.track_sel; na = bus.track_sel ? A1S : A0S; ld = 1'b1; st = 1;
        end else if (st == 2) st = 1;
      end else if (bus.cmd_pause) begin
        if (st == 1) st = 2;
      end
      if (ld) begin m_le = n_edge; m_has = 1'b1; end
      m_state = st;
      m_addr  = na;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rom_addr",     32'(bus.rom_addr),     32'(m_addr));
    check("audio_output", 32'(bus.audio_output), 32'(m_out));
    check("playing",      32'(bus.playing),      32'(m_state == 1));
    check("track_done",   32'(bus.track_done),   32'(m_done));
    check("underrun",     32'(bus.underrun),     32'(m_under));
  endtask

  task automatic clr();
    reset = 1'b0; bus.sample_req = 1'b0; bus.sample_end = 1'b0;
    bus.cmd_play = 1'b0; bus.cmd_pause = 1'b0; bus.cmd_stop = 1'b0;
  endtask

  task automatic rst_tick();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_n(input int k);
    repeat (k) tick();
  endtask

  task automatic req_tick();
    bus.sample_req = 1'b1; tick(); bus.sample_req = 1'b0;
  endtask

  task automatic play_tick(input logic trk);
    bus.track_sel = trk; bus.cmd_play = 1'b1; tick(); bus.cmd_play = 1'b0;
  endtask

  typedef struct {
    logic        rst, req, se, play, pause, stop, trk;
    logic [1:0]  mode;
    logic [15:0] ain;
    logic [19:0] e_addr;
    logic [15:0] e_out;
    logic        e_play, e_done, e_und;
  } vec_t;

  vec_t tab [15];

  initial begin
    // rst req se play pause stop trk mode ain | addr out playing done underrun
    tab[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd0, 16'h0,         1'b0,1'b0,1'b0};
    tab[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd0, 16'h0,         1'b0,1'b0,1'b0};
    tab[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd0, 16'h0,         1'b1,1'b0,1'b0};
    tab[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd0, 16'h0,         1'b1,1'b0,1'b1};
    tab[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd0, 16'h0,         1'b1,1'b0,1'b0};
    tab[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd1, rom_val(20'd0),1'b1,1'b0,1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,16'h0,    20'd1, rom_val(20'd0),1'b0,1'b0,1'b0};
    tab[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd1, 16'h0,         1'b0,1'b0,1'b0};
    tab[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,16'h1234, 20'd1, 16'h0,         1'b0,1'b0,1'b0};
    tab[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,16'h0,    20'd1, 16'h1234,      1'b0,1'b0,1'b0};
    tab[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd1, 16'h1234,      1'b1,1'b0,1'b0};
    tab[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'h0,    20'd2, rom_val(20'd1),1'b1,1'b0,1'b0};
    tab[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,16'h0,    20'd0, rom_val(20'd1),1'b0,1'b0,1'b0};
    tab[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b01,16'h0,    20'd16,rom_val(20'd1),1'b1,1'b0,1'b0};
    tab[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,16'h0,    20'd16,16'h0,         1'b1,1'b0,1'b0};

    n_edge = 0; m_le = 0; m_state = 0; m_addr = A0S; m_trk = 1'b0; m_has = 1'b0;
    m_out = 16'h0; m_last = 16'h0; m_done = 1'b0; m_under = 1'b0;
    clr();
    bus.audio_input = 16'h0; bus.mode = 2'b01; bus.track_sel = 1'b0; bus.loop_en = 1'b0;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      reset = tab[i].rst; bus.sample_req = tab[i].req; bus.sample_end = tab[i].se;
      bus.cmd_play = tab[i].play; bus.cmd_pause = tab[i].pause; bus.cmd_stop = tab[i].stop;
      bus.track_sel = tab[i].trk; bus.mode = tab[i].mode; bus.audio_input = tab[i].ain;
      tick();
      check($sformatf("vec%0d_addr", i),  32'(bus.rom_addr),     32'(tab[i].e_addr));
      check($sformatf("vec%0d_out", i),   32'(bus.audio_output), 32'(tab[i].e_out));
      check($sformatf("vec%0d_play", i),  32'(bus.playing),      32'(tab[i].e_play));
      check($sformatf("vec%0d_done", i),  32'(bus.track_done),   32'(tab[i].e_done));
      check($sformatf("vec%0d_under", i), 32'(bus.underrun),     32'(tab[i].e_und));
      clr();
    end

    // Track 0 once through without looping, then one request in idle
    bus.mode = 2'b01; bus.loop_en = 1'b0;
    rst_tick();
    play_tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_n(7); req_tick();
      check("t1_out",  32'(bus.audio_output), (i < 4) ? 32'(rom_val(20'(i))) : 32'h0);
      check("t1_done", 32'(bus.track_done),   32'(i == 3));
    end
    check("t1_idle", 32'(bus.playing), 32'h0);

    // Track 0 looping
    bus.loop_en = 1'b1;
    rst_tick();
    play_tick(1'b0);
    for (int i = 0; i < 9; i++) begin
      wait_n(7); req_tick();
      check("t2_out",  32'(bus.audio_output), 32'(rom_val(20'(i % 4))));
      check("t2_done", 32'(bus.track_done),   32'((i % 4) == 3));
    end
    check("t2_playing", 32'(bus.playing), 32'h1);

    // Pause holds the address; resume plays the next word without refetch delay
    bus.loop_en = 1'b0;
    rst_tick();
    play_tick(1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_n(7); req_tick();
      check("t3_play_out", 32'(bus.audio_output), 32'(rom_val(20'(i))));
    end
    bus.cmd_pause = 1'b1; tick(); bus.cmd_pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_n(7); req_tick();
      check("t3_pause_out",  32'(bus.audio_output), 32'h0);
      check("t3_pause_addr", 32'(bus.rom_addr),     32'd2);
    end
    play_tick(1'b0);
    req_tick();
    check("t3_resume_out", 32'(bus.audio_output), 32'(rom_val(20'd2)));

    // Reset in the middle of track 1
    rst_tick();
    play_tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_n(7); req_tick();
    end
    check("t6_mid_addr", 32'(bus.rom_addr), 32'd19);
    check("t6_mid_play", 32'(bus.playing),  32'h1);
    rst_tick();
    check("t6_addr", 32'(bus.rom_addr),     32'(A0S));
    check("t6_play", 32'(bus.playing),      32'h0);
    check("t6_out",  32'(bus.audio_output), 32'h0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(299) == 0);
      bus.sample_req  = ($urandom_range(3) == 0);
      bus.sample_end  = ($urandom_range(3) == 0);
      bus.audio_input = 16'($urandom);
      bus.mode        = ($urandom_range(4) == 0) ? 2'($urandom) : 2'b01;
      bus.cmd_play    = ($urandom_range(19) == 0);
      bus.cmd_pause   = ($urandom_range(24) == 0);
      bus.cmd_stop    = ($urandom_range(39) == 0);
      bus.track_sel   = 1'($urandom);
      if ($urandom_range(7) == 0) bus.loop_en = 1'($urandom);
      tick();
    end
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
